// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS9 (x^9+x^5+1) lock detector and BER counter
module prbs_checker #(
  parameter int NB_CNT      = 32,
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              bit_in,
  input  logic              clear,
  output logic              locked,
  output logic              error,
  output logic [NB_CNT-1:0] err_count,
  output logic [NB_CNT-1:0] bit_count
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam logic [NB_CNT-1:0] MAX = '1;
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t          state, state_d;
  logic [8:0]      h, h_d;
  logic [3:0]      fill, fill_d;
  logic [MW-1:0]   match, match_d;
  logic [WW-1:0]   win_cnt, win_cnt_d;
  logic [EW-1:0]   win_err, win_err_d;
  logic            p, miss, cnt_en, wrap;
  assign p      = h[8] ^ h[4];
  assign miss   = bit_in ^ p;
  assign wrap   = win_cnt == WW'(WINDOW - 1);
  assign locked = state == LOCKED;
  // next state: search shifts received bits, locked state free-runs on its own prediction
  always_comb begin
    state_d   = state;
    h_d       = h;
    fill_d    = fill;
    match_d   = match;
    win_cnt_d = win_cnt;
    win_err_d = win_err;
    cnt_en    = 1'b0;
    if (valid && state == SEARCH) begin
      h_d = {h[7:0], bit_in};
      if (fill < 4'd9) fill_d = fill + 4'd1;
      else if (!miss && h != '0) begin
        match_d = match + MW'(1);
        if (match_d == MW'(LOCK_COUNT)) begin
          state_d   = LOCKED;
          win_cnt_d = '0;
          win_err_d = '0;
        end
      end else match_d = '0;
    end else if (valid) begin
      cnt_en    = 1'b1;
      h_d       = {h[7:0], p};
      win_err_d = win_err + EW'(miss);
      win_cnt_d = wrap ? '0 : win_cnt + WW'(1);
      if (win_err_d == EW'(LOSS_THRESH)) begin
        state_d   = SEARCH;
        h_d       = '0;
        fill_d    = '0;
        match_d   = '0;
        win_cnt_d = '0;
        win_err_d = '0;
      end else if (wrap) win_err_d = '0;
    end
  end
  // state, history and window tracking registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SEARCH;
      h       <= '0;
      fill    <= '0;
      match   <= '0;
      win_cnt <= '0;
      win_err <= '0;
    end else begin
      state   <= state_d;
      h       <= h_d;
      fill    <= fill_d;
      match   <= match_d;
      win_cnt <= win_cnt_d;
      win_err <= win_err_d;
    end
  end
  // error pulse and saturating counters; clear beats a same-edge increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      error     <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      error <= cnt_en && miss;
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (cnt_en) begin
        if (bit_count != MAX) bit_count <= bit_count + 1'b1;
        if (miss && err_count != MAX) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed and randomized checks of prbs_checker against a queue-based model
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        rst = 1'b0, valid = 1'b0, bit_in = 1'b0, clear = 1'b0;
  logic        locked, error;
  logic [31:0] err_count, bit_count;
  int          n_vec = 0, n_err = 0;
  prbs_checker dut (
    .clk(clk), .rst(rst), .valid(valid), .bit_in(bit_in), .clear(clear),
    .locked(locked), .error(error), .err_count(err_count), .bit_count(bit_count)
  );
  always #5 clk = ~clk;
  // transmitter-side PRBS9 source
  logic [8:0] gs = 9'h1AA;
  function automatic logic gen();
    logic o;
    o  = gs[8] ^ gs[4];
    gs = {gs[7:0], o};
    return o;
  endfunction
  // reference model: history as a queue of bits, counts as plain integers
  bit     m_hist[$];
  bit     m_locked, m_error;
  int     m_match, m_win, m_werr;
  longint m_err, m_bits;
  task automatic model(input logic r, v, b, c);
    bit pred, nz, miss;
    int n;
    if (!r) begin
      m_hist.delete();
      m_locked = 0; m_error = 0; m_match = 0; m_win = 0; m_werr = 0; m_err = 0; m_bits = 0;
      return;
    end
    m_error = 0;
    if (v) begin
      n = m_hist.size();
      pred = (n >= 9) ? (m_hist[n-9] ^ m_hist[n-5]) : 1'b0;
      if (!m_locked) begin
        if (n >= 9) begin
          nz = 0;
          for (int i = n - 9; i < n; i++) nz |= m_hist[i];
          m_match = (b == pred && nz) ? m_match + 1 : 0;
        end
        m_hist.push_back(b);
        if (m_match == 16) begin
          m_locked = 1; m_win = 0; m_werr = 0;
        end
      end else begin
        miss = (b != pred);
        m_hist.push_back(pred);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (miss) begin
          if (m_err < 64'hFFFF_FFFF) m_err++;
          m_werr++;
          m_error = 1;
        end
        m_win++;
        if (m_werr == 8) begin
          m_locked = 0; m_hist.delete(); m_match = 0; m_win = 0; m_werr = 0;
        end else if (m_win == 64) begin
          m_win = 0; m_werr = 0;
        end
      end
      while (m_hist.size() > 9) void'(m_hist.pop_front());
    end
    if (c) begin
      m_err = 0; m_bits = 0;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // one clock: drive on falling edge, model the rising edge, compare shortly after it
  task automatic cyc(input logic r, v, b, c);
    @(negedge clk);
    rst = r; valid = v; bit_in = b; clear = c;
    @(posedge clk);
    model(r, v, b, c);
    #1;
    chk("locked", 64'(locked), 64'(m_locked));
    chk("error", 64'(error), 64'(m_error));
    chk("err_count", 64'(err_count), m_err);
    chk("bit_count", 64'(bit_count), m_bits);
  endtask
  task automatic clean(input int n);
    repeat (n) cyc(1, 1, gen(), 0);
  endtask
  int ev;
  initial begin
    repeat (3) cyc(0, 0, 0, 0);
    chk("reset_locked", 64'(locked), 0);
    chk("reset_counts", 64'(err_count | bit_count), 0);
    clean(24);
    chk("prelock_24", 64'(locked), 0);
    clean(1);
    chk("lock_at_25", 64'(locked), 1);
    ev = 0;
    repeat (1000) begin
      cyc(1, 1, gen(), 0);
      ev += int'(error);
    end
    chk("clean_bits_1000", 64'(bit_count), 1000);
    chk("clean_errs_0", 64'(err_count), 0);
    chk("clean_no_pulse", 64'(ev), 0);
    cyc(1, 1, ~gen(), 0);
    chk("single_err_pulse", 64'(error), 1);
    chk("single_err_count", 64'(err_count), 1);
    clean(1);
    chk("single_pulse_ends", 64'(error), 0);
    clean(100);
    chk("flywheel_err_count", 64'(err_count), 1);
    chk("flywheel_locked", 64'(locked), 1);
    while (m_win != 10) clean(1);
    repeat (7) cyc(1, 1, ~gen(), 0);
    chk("burst_7_locked", 64'(locked), 1);
    cyc(1, 1, ~gen(), 0);
    chk("burst_8_unlock", 64'(locked), 0);
    chk("burst_err_count", 64'(err_count), 9);
    clean(24);
    chk("relock_24", 64'(locked), 0);
    clean(1);
    chk("relock_25", 64'(locked), 1);
    clean(30);
    chk("relock_continue", 64'(bit_count), 1000 + 1 + 101 + 64'(m_bits) - 1102);
    cyc(0, 0, 0, 0);
    repeat (500) cyc(1, 1, 0, 0);
    chk("zeros_unlocked", 64'(locked), 0);
    chk("zeros_counts", 64'(err_count | bit_count), 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      if (k == 24) chk("sparse_prelock", 64'(locked), 0);
      cyc(1, 0, 1'($urandom), 0);
      cyc(1, 0, 1'($urandom), 0);
      cyc(1, 1, gen(), 0);
    end
    chk("sparse_lock", 64'(locked), 1);
    clean(40);
    cyc(1, 1, ~gen(), 1);
    chk("clear_counts", 64'(err_count | bit_count), 0);
    chk("clear_keeps_lock", 64'(locked), 1);
    chk("clear_pulse", 64'(error), 1);
    clean(5);
    chk("after_clear_bits", 64'(bit_count), 5);
    cyc(0, 1, gen(), 0);
    chk("rst_unlock", 64'(locked), 0);
    chk("rst_counts", 64'(err_count | bit_count), 0);
    clean(24);
    chk("rst_relock_24", 64'(locked), 0);
    clean(1);
    chk("rst_relock_25", 64'(locked), 1);
    for (int i = 0; i < 4000; i++) begin
      int rate;
      logic v;
      rate = ((i / 500) % 2) ? 3 : 60;
      v = $urandom_range(0, 3) != 0;
      cyc($urandom_range(0, 699) != 0, v, v ? (gen() ^ ($urandom_range(0, rate - 1) == 0)) : 1'($urandom),
          $urandom_range(0, 249) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the PRBS9 generator; recovers lock on an incoming PRBS9 bit stream and counts bit errors for BER measurement.
- Sits after the QPSK demodulator/slicer, one bit per valid strobe.
- Self-synchronising, so it is independent of the transmitter seed.
- Lock is held with a locally regenerated flywheel sequence so that received errors do not propagate.

Parameters:
- NB_CNT, 32, width of the bit and error counters (saturating).
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- WINDOW, 64, valid bits per loss-of-lock observation window.
- LOSS_THRESH, 8, errors within one window that force loss of lock.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  received bit.
- clear  input  1  synchronous clear of err_count/bit_count; lock state is unaffected.
- locked  output  1  checker is synchronised.
- error  output  1  one-cycle pulse: the last valid bit mismatched while locked.
- err_count  output  NB_CNT  errored bits counted while locked.
- bit_count  output  NB_CNT  bits compared while locked.

Behaviour:
- Sequence definition: PRBS9, x^9+x^5+1, recurrence b[n] = b[n-9] XOR b[n-5]. The checker keeps a 9-bit history h of the last 9 bits and predicts p = h[n-9] XOR h[n-5].
- Reset (rst=0 at a clock edge): state=SEARCH, h=0, fill/match/window counters=0, locked=0, error=0, err_count=0, bit_count=0. Reset overrides every other input, including mid-operation.
- Cycles with valid=0: no state, history, counter or output changes, except error, which returns to 0.
- SEARCH state:
  - Each valid bit shifts bit_in into h.
  - The first 9 valid bits only fill h.
  - After that, each valid bit is compared with p. A match with h≠0 increments match_cnt; a mismatch, or h==0, clears match_cnt to 0.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED. locked=1 on the edge after the LOCK_COUNT-th match; window counter and window error count are cleared.
  - With defaults, lock is declared after valid bit #25.
- LOCKED state:
  - Each valid bit shifts p, not bit_in, into h (flywheel). h can never become all-zero.
  - bit_count increments on every valid bit.
  - If bit_in≠p: err_count increments, win_err increments, and error=1 for exactly the next cycle.
  - win_cnt counts valid bits. On the WINDOW-th bit it wraps to 0 and win_err is cleared; an error on the wrap bit is counted toward the old window first.
  - When win_err reaches LOSS_THRESH: next state is SEARCH, locked=0 on that same edge, and fill/match counters and h are cleared. The errored bit is still counted in err_count and pulses error.
- Registered outputs: all outputs change on the clock edge that samples the valid bit, giving one-cycle latency.
- Counters:
  - Saturate at 2^NB_CNT−1 and never wrap.
  - err_count ≤ bit_count at all times.
  - When clear and a valid increment occur on the same edge, clear wins: both counters go to 0 and that bit is not counted.
  - The error pulse is still generated while clear is asserted.
- Counters hold their values through loss of lock; only rst or clear zeroes them.

Test Plan:
- Clean PRBS9 stream from the generator (seed 0x1AA), valid every cycle after reset release -> locked rises on the edge after valid bit #25. After 1000 further bits: bit_count=1000, err_count=0, error never asserted.
- Locked, invert the single bit at stream index 200 -> error high for one cycle, err_count=1. No further errors (flywheel), locked stays 1.
- Locked, invert 8 consecutive bits inside one window -> err_count=8, locked falls on the edge sampling the 8th errored bit. Relock occurs 25 valid bits after clean data resumes; counters keep 8 and continue from there.
- All-zero input with valid=1 for 500 cycles -> locked stays 0, err_count=bit_count=0.
- valid asserted every 3rd cycle with a clean stream -> lock after the 25th valid bit (cycle ~75). bit_in values driven on valid=0 cycles are ignored, even when they are random.
- While locked, mid-count: assert clear together with valid for 1 cycle -> both counters read 0 next cycle and locked stays 1. Then drive rst=0 for 1 cycle -> locked=0, all counters 0; relock takes 25 valid bits.
